// File: rtl/mf_coeff_if.sv
// mf_coeff_if: loader handshake bundle (read_MIF_file stream in, coefficient read port out)
interface mf_coeff_if #(
  parameter int LENGTH     = 800,
  parameter int DATA_WIDTH = 12
);
  localparam int AW = $clog2(LENGTH);
  logic                         loadStart;
  logic                         mifEnable;
  logic signed [DATA_WIDTH-1:0] mifInRe;
  logic signed [DATA_WIDTH-1:0] mifInIm;
  logic                         mifFinishedFlag;
  logic        [AW-1:0]         coeffAddr;
  logic signed [DATA_WIDTH-1:0] coeffRe;
  logic signed [DATA_WIDTH-1:0] coeffIm;
  logic                         coeffReady;
  logic                         loadBusy;
  logic                         loadError;
  modport slave (
    input  loadStart, mifInRe, mifInIm, mifFinishedFlag, coeffAddr,
    output mifEnable, coeffRe, coeffIm, coeffReady, loadBusy, loadError
  );
  modport master (
    output loadStart, mifInRe, mifInIm, mifFinishedFlag, coeffAddr,
    input  mifEnable, coeffRe, coeffIm, coeffReady, loadBusy, loadError
  );
endinterface

// File: rtl/mf_coeff_loader.sv
// mf_coeff_loader: loads LENGTH complex coefficients from read_MIF_file into RAM and serves them; MF_CONJ_REVERSE_EN selects time-reversed conjugate reads
module mf_coeff_loader #(
  parameter int LENGTH     = 800,
  parameter int DATA_WIDTH = 12
) (
  input logic       clock,
  input logic       reset,
  mf_coeff_if.slave bus
);
  localparam int AW = $clog2(LENGTH);
  localparam logic [AW-1:0] LAST = AW'(LENGTH - 1);
  typedef enum logic [1:0] {IDLE, ARM, LOAD, READY} state_t;
  state_t                    r_state, w_state;
  logic [AW-1:0]             r_cnt, w_cnt;
  logic                      r_en, w_en, r_busy, w_busy, r_rdy, w_rdy, r_err, w_err;
  logic                      r_chk, w_chk, r_fin, w_fin, w_we;
  logic [2*DATA_WIDTH-1:0]   r_ram [LENGTH];
  logic [DATA_WIDTH-1:0]     r_re, r_im;
  logic [AW-1:0]             w_addr;
  logic                      w_oor;
  logic [2*DATA_WIDTH-1:0]   w_word;
  logic [DATA_WIDTH-1:0]     w_re, w_im, w_raw_im;
  // Next state and next control outputs; r_chk marks the one cycle where a late end-of-data is judged
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_en    = r_en;
    w_busy  = r_busy;
    w_rdy   = r_rdy;
    w_err   = r_err;
    w_chk   = 1'b0;
    w_fin   = r_fin;
    w_we    = 1'b0;
    case (r_state)
      IDLE, READY: begin
        if (r_chk && !(r_fin || bus.mifFinishedFlag)) w_err = 1'b1;
        if (bus.loadStart) begin
          w_state = ARM;
          w_en    = 1'b1;
          w_busy  = 1'b1;
          w_rdy   = 1'b0;
          w_err   = 1'b0;
          w_cnt   = '0;
          w_fin   = 1'b0;
        end
      end
      ARM: w_state = LOAD;
      LOAD: begin
        w_we  = 1'b1;
        w_cnt = r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          w_state = READY;
          w_en    = 1'b0;
          w_busy  = 1'b0;
          w_rdy   = 1'b1;
          w_chk   = 1'b1;
          w_fin   = bus.mifFinishedFlag;
        end else if (bus.mifFinishedFlag) begin
          w_state = IDLE;
          w_err   = 1'b1;
          w_en    = 1'b0;
          w_busy  = 1'b0;
          w_rdy   = 1'b0;
        end
      end
      default: w_state = IDLE;
    endcase
  end
  // State and control registers; reset abandons any partial load
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
      r_chk   <= 1'b0;
      r_fin   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_en    <= w_en;
      r_busy  <= w_busy;
      r_rdy   <= w_rdy;
      r_err   <= w_err;
      r_chk   <= w_chk;
      r_fin   <= w_fin;
    end
  end
  // Coefficient RAM write; contents survive reset, validity is tracked by coeffReady
  always_ff @(posedge clock) begin
    if (w_we) r_ram[r_cnt] <= {bus.mifInRe, bus.mifInIm};
  end
`ifdef MF_CONJ_REVERSE_EN
  localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  assign w_addr = LAST - bus.coeffAddr;
  assign w_im   = (w_raw_im == SMIN) ? SMAX : -w_raw_im;
`else
  assign w_addr = bus.coeffAddr;
  assign w_im   = w_raw_im;
`endif
  assign w_oor    = int'(bus.coeffAddr) >= LENGTH;
  assign w_word   = r_ram[w_addr];
  assign w_re     = w_word[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_raw_im = w_word[DATA_WIDTH-1:0];
  // Registered read port, one cycle latency; out-of-range addresses read as zero
  always_ff @(posedge clock) begin
    if (reset) begin
      r_re <= '0;
      r_im <= '0;
    end else begin
      r_re <= w_oor ? '0 : w_re;
      r_im <= w_oor ? '0 : w_im;
    end
  end
  assign bus.mifEnable  = r_en;
  assign bus.loadBusy   = r_busy;
  assign bus.coeffReady = r_rdy;
  assign bus.loadError  = r_err;
  assign bus.coeffRe    = r_re;
  assign bus.coeffIm    = r_im;
endmodule
